// File: rtl/vga_color_sequencer.sv
// Frame-synchronous colour-select controller: synchronizes and debounces board switches,
// applies them only at the start of vertical blanking, and optionally auto-cycles colours.
module vga_color_sequencer #(
    parameter int DB_CYCLES       = 500000,
    parameter int DB_W            = 20,
    parameter int FRAMES_PER_STEP = 30,
    parameter int V_BLANK_START   = 480
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       pix_tick,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [2:0] sw_rgb,
    input  logic       sw_auto,
    output logic [2:0] ctrl_rgb,
    output logic       frame_tick,
    output logic       mode_auto
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [9:0]      VB_ROW  = 10'(V_BLANK_START);

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_AUTO   = 1'b1;

    logic [3:0]      s1_q, s2_q, s2d_q;
    logic [3:0]      stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [0:0]      state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [2:0]      rgb_q, rgb_d;
    logic            ftick_q;
    logic            fb_s;
    logic            db_clear_s;

    // Auto-mode colour step; wraps 7 back to 1 so black is never produced.
    function automatic logic [2:0] next_color(input logic [2:0] c);
        next_color = (c == 3'b111) ? 3'b001 : (c + 3'b001);
    endfunction

    assign fb_s       = pix_tick && (pix_x == 10'd0) && (pix_y == VB_ROW);
    assign db_clear_s = (s2_q == stable_q) || (s2_q != s2d_q);

    // Debounce: accept s2 only after it has held a new value for DB_CYCLES cycles.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (db_clear_s) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    // Mode/colour state machine, advanced only on frame-boundary cycles.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        rgb_d   = rgb_q;
        if (fb_s) begin
            case (state_q)
                ST_MANUAL: begin
                    if (stable_q[3]) begin
                        state_d = ST_AUTO;
                        rgb_d   = (rgb_q != 3'b000) ? rgb_q : 3'b001;
                        fcnt_d  = '0;
                    end else begin
                        rgb_d = stable_q[2:0];
                    end
                end
                ST_AUTO: begin
                    if (!stable_q[3]) begin
                        state_d = ST_MANUAL;
                        rgb_d   = stable_q[2:0];
                        fcnt_d  = '0;
                    end else if (fcnt_q == FC_LAST) begin
                        fcnt_d = '0;
                        rgb_d  = next_color(rgb_q);
                    end else begin
                        fcnt_d = fcnt_q + FC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_MANUAL;
                    fcnt_d  = '0;
                    rgb_d   = 3'b000;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // All state registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q     <= 4'b0000;
            s2_q     <= 4'b0000;
            s2d_q    <= 4'b0000;
            stable_q <= 4'b0000;
            cnt_q    <= '0;
            state_q  <= ST_MANUAL;
            fcnt_q   <= '0;
            rgb_q    <= 3'b000;
            ftick_q  <= 1'b0;
        end else begin
            s1_q     <= {sw_auto, sw_rgb};
            s2_q     <= s1_q;
            s2d_q    <= s2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            rgb_q    <= rgb_d;
            ftick_q  <= fb_s;
        end
    end

    assign ctrl_rgb   = rgb_q;
    assign frame_tick = ftick_q;
    assign mode_auto  = (state_q == ST_AUTO);

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Directed bench for vga_color_sequencer on a tiny 8x5 scan with short debounce and dwell.
module tb_vga_color_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       pix_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [2:0] sw_rgb;
    logic       sw_auto;
    logic [2:0] ctrl_rgb;
    logic       frame_tick;
    logic       mode_auto;

    int n_checks = 0;
    int n_fail   = 0;
    int sx = 0;
    int sy = 3;
    logic kill_tick = 1'b0;

    typedef struct packed {
        logic       sw_auto;
        logic [2:0] sw_rgb;
        logic [2:0] exp_rgb;
        logic       exp_mode;
    } vec_t;

    vec_t vecs [17];

    vga_color_sequencer #(
        .DB_CYCLES(4),
        .DB_W(3),
        .FRAMES_PER_STEP(2),
        .V_BLANK_START(3)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .pix_tick(pix_tick),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .sw_rgb(sw_rgb),
        .sw_auto(sw_auto),
        .ctrl_rgb(ctrl_rgb),
        .frame_tick(frame_tick),
        .mode_auto(mode_auto)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive_scan();
        pix_x    = 10'(sx);
        pix_y    = 10'(sy);
        pix_tick = !(kill_tick && sx == 0 && sy == 3);
    endtask

    // One clock: sample point is 1 time unit after the rising edge, then advance the scan.
    task automatic tick();
        @(posedge CLK);
        #1;
        sx = sx + 1;
        if (sx == 8) begin
            sx = 0;
            sy = (sy + 1) % 5;
        end
        drive_scan();
    endtask

    // Run to the next frame_tick, checking ctrl_rgb holds until then.
    task automatic wait_frame(input string name);
        logic [2:0] prev;
        logic       seen;
        logic       moved;
        prev  = ctrl_rgb;
        seen  = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (frame_tick) seen = 1'b1;
            else if (ctrl_rgb !== prev) moved = 1'b1;
        end
        check({name, "_frame_seen"}, {3'b000, seen}, 4'b0001);
        check({name, "_hold"}, {3'b000, moved}, 4'b0000);
    endtask

    initial begin
        int ft_count;
        vecs[0]  = '{1'b1, 3'b011, 3'b011, 1'b1};
        vecs[1]  = '{1'b1, 3'b011, 3'b011, 1'b1};
        vecs[2]  = '{1'b1, 3'b011, 3'b100, 1'b1};
        vecs[3]  = '{1'b1, 3'b011, 3'b100, 1'b1};
        vecs[4]  = '{1'b1, 3'b011, 3'b101, 1'b1};
        vecs[5]  = '{1'b1, 3'b011, 3'b101, 1'b1};
        vecs[6]  = '{1'b1, 3'b011, 3'b110, 1'b1};
        vecs[7]  = '{1'b1, 3'b010, 3'b110, 1'b1};
        vecs[8]  = '{1'b0, 3'b010, 3'b010, 1'b0};
        vecs[9]  = '{1'b0, 3'b111, 3'b111, 1'b0};
        vecs[10] = '{1'b1, 3'b111, 3'b111, 1'b1};
        vecs[11] = '{1'b1, 3'b111, 3'b111, 1'b1};
        vecs[12] = '{1'b1, 3'b111, 3'b001, 1'b1};
        vecs[13] = '{1'b0, 3'b000, 3'b000, 1'b0};
        vecs[14] = '{1'b1, 3'b000, 3'b001, 1'b1};
        vecs[15] = '{1'b1, 3'b000, 3'b001, 1'b1};
        vecs[16] = '{1'b1, 3'b000, 3'b010, 1'b1};

        // Reset held across a boundary position with switches at 101.
        RESET   = 1'b1;
        sw_rgb  = 3'b101;
        sw_auto = 1'b0;
        drive_scan();
        tick();
        tick();
        tick();
        check("rst_rgb", {1'b0, ctrl_rgb}, 4'b0000);
        check("rst_mode", {3'b000, mode_auto}, 4'b0000);
        check("rst_ftick", {3'b000, frame_tick}, 4'b0000);
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("pre_fb_rgb", {1'b0, ctrl_rgb}, 4'b0000);
        wait_frame("first");
        check("first_rgb", {1'b0, ctrl_rgb}, 4'b0101);
        check("first_mode", {3'b000, mode_auto}, 4'b0000);
        tick();
        check("ftick_pulse", {3'b000, frame_tick}, 4'b0000);

        // Three-cycle glitch must never reach the output.
        sw_rgb = 3'b010;
        tick();
        tick();
        tick();
        sw_rgb = 3'b101;
        wait_frame("glitch1");
        check("glitch1_rgb", {1'b0, ctrl_rgb}, 4'b0101);
        wait_frame("glitch2");
        check("glitch2_rgb", {1'b0, ctrl_rgb}, 4'b0101);

        // Mid-frame change; the boundary of this frame has pix_tick low and is ignored.
        kill_tick = 1'b1;
        sw_rgb    = 3'b011;
        ft_count  = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (frame_tick) ft_count++;
        end
        check("masked_fb_ticks", 4'(ft_count), 4'b0000);
        check("masked_fb_rgb", {1'b0, ctrl_rgb}, 4'b0101);
        kill_tick = 1'b0;
        wait_frame("midframe");
        check("midframe_rgb", {1'b0, ctrl_rgb}, 4'b0011);

        // Table: switch setting applied right after a boundary, checked at the next one.
        for (int v = 0; v < 17; v++) begin
            sw_auto = vecs[v].sw_auto;
            sw_rgb  = vecs[v].sw_rgb;
            wait_frame($sformatf("vec%0d", v));
            check($sformatf("vec%0d_rgb", v), {1'b0, ctrl_rgb}, {1'b0, vecs[v].exp_rgb});
            check($sformatf("vec%0d_mode", v), {3'b000, mode_auto}, {3'b000, vecs[v].exp_mode});
        end

        // One-cycle reset mid-frame while in AUTO, then recovery into AUTO from 000.
        for (int i = 0; i < 10; i++) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("midrst_rgb", {1'b0, ctrl_rgb}, 4'b0000);
        check("midrst_mode", {3'b000, mode_auto}, 4'b0000);
        check("midrst_ftick", {3'b000, frame_tick}, 4'b0000);
        wait_frame("recover");
        check("recover_rgb", {1'b0, ctrl_rgb}, 4'b0001);
        check("recover_mode", {3'b000, mode_auto}, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
